// File: rtl/upload_flit_fifo_if.sv
// Flit stream bundle between the upload datapath, the store-and-forward FIFO and the ring side.
interface upload_flit_fifo_if #(
  parameter int unsigned AW  = 4,
  parameter int unsigned MCW = 4
);
  logic [15:0]    flit_in;
  logic           push;
  logic           push_last;
  logic           full;
  logic [15:0]    flit_out;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic [MCW-1:0] msg_cnt;
  logic [AW:0]    occ;
  logic           err_overflow;

  modport master (
    output flit_in, push, push_last, out_ready,
    input  full, flit_out, out_valid, out_last, msg_cnt, occ, err_overflow
  );

  modport slave (
    input  flit_in, push, push_last, out_ready,
    output full, flit_out, out_valid, out_last, msg_cnt, occ, err_overflow
  );
endinterface

// File: rtl/upload_flit_fifo.sv
// Store-and-forward flit buffer: a message is released only once its last flit is stored,
// so the output stream never starves mid-message.
module upload_flit_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned MCW   = 4
) (
  input logic                clk,
  input logic                rst,
  upload_flit_fifo_if.slave  bus
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam int unsigned McMax  = (1 << MCW) - 1;

  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q;
  // Internal message count is as wide as occupancy so it can never wrap.
  logic [AW:0]   cnt_q;
  logic          err_q;

  logic          full;
  logic          out_valid;
  logic          wr_en;
  logic          rd_en;
  logic          head_last;
  logic [16:0]   head;

  assign full      = (occ_q == DepthW);
  assign out_valid = (cnt_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_last = out_valid & head[16];
  assign wr_en     = bus.push & ~full;
  assign rd_en     = out_valid & bus.out_ready;

  assign bus.full         = full;
  assign bus.out_valid    = out_valid;
  assign bus.flit_out     = out_valid ? head[15:0] : 16'h0000;
  assign bus.out_last     = head_last;
  assign bus.occ          = occ_q;
  assign bus.err_overflow = err_q;

  always_comb begin
    bus.msg_cnt = '1;
    if (32'(cnt_q) <= McMax) bus.msg_cnt = MCW'(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {bus.push_last, bus.flit_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;

      unique case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      unique case ({wr_en & bus.push_last, rd_en & head_last})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (bus.push & full) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upload_flit_fifo.sv
// Directed bench for upload_flit_fifo: vector table for single messages, hand sequences for
// fill/overflow, pointer wrap and reset mid-message.
module tb_upload_flit_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  upload_flit_fifo_if #(.AW(4), .MCW(4)) bus ();

  upload_flit_fifo #(.DEPTH(16), .AW(4), .MCW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        push;
    logic        last;
    logic [15:0] din;
    logic        rdy;
    logic        ev;
    logic [15:0] ef;
    logic        el;
    int          ecnt;
    int          eocc;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(logic push, logic last, logic [15:0] din, logic rdy,
                              logic ev, logic [15:0] ef, logic el, int ecnt, int eocc);
    vec_t v;
    v.push = push; v.last = last; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ef = ef; v.el = el; v.ecnt = ecnt; v.eocc = eocc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  // Apply inputs after the falling edge, let them settle, then compare.
  task automatic drive(input logic push, input logic last, input logic [15:0] din,
                       input logic rdy);
    @(negedge clk);
    bus.push = push; bus.push_last = last; bus.flit_in = din; bus.out_ready = rdy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [15:0] ef,
                         input logic el, input int ecnt, input int eocc);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".flit"},  32'(bus.flit_out),  32'(ef));
    chk({tag, ".last"},  32'(bus.out_last),  32'(el));
    chk({tag, ".cnt"},   32'(bus.msg_cnt),   32'(ecnt));
    chk({tag, ".occ"},   32'(bus.occ),       32'(eocc));
  endtask

  initial begin
    bus.push = 1'b0; bus.push_last = 1'b0; bus.flit_in = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 16'h0, 1'b0, 0, 0);
    chk("reset.full", 32'(bus.full), 32'd0);
    chk("reset.err", 32'(bus.err_overflow), 32'd0);

    // 3-flit message with ready high, then the same message under 5 cycles of backpressure
    vecs.push_back(mk(1, 0, 16'h4123, 1, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0A00, 1, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0B00, 1, 0, 16'h0000, 0, 0, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h4123, 0, 1, 3));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0A00, 0, 1, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0B00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h4123, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0A00, 0, 0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0B00, 0, 0, 16'h0000, 0, 0, 2));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h4123, 0, 1, 3));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h4123, 0, 1, 3));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0A00, 0, 1, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0B00, 1, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].last, vecs[i].din, vecs[i].rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ef, vecs[i].el,
              vecs[i].ecnt, vecs[i].eocc);
    end

    // Fill with four 4-flit messages, then overflow
    for (int i = 0; i < 16; i++) drive(1'b1, (i % 4) == 3, 16'h1000 + 16'(i), 1'b0);
    drive(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.cnt", 32'(bus.msg_cnt), 32'd4);
    chk("fill.occ", 32'(bus.occ), 32'd16);
    chk("fill.err_pre", 32'(bus.err_overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1);
      if (i == 0) chk("ovf.err", 32'(bus.err_overflow), 32'd1);
      chk_out($sformatf("drain%0d", i), 1'b1, 16'h1000 + 16'(i), (i % 4) == 3,
              4 - i / 4, 16 - i);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("drained", 1'b0, 16'h0, 1'b0, 0, 0);
    chk("drained.err", 32'(bus.err_overflow), 32'd1);
    chk("drained.full", 32'(bus.full), 32'd0);

    // Twenty 1-flit messages streamed through: one in, one out each cycle
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 16'(k), 1'b1);
      if (k == 0) chk_out("wrap0", 1'b0, 16'h0, 1'b0, 0, 0);
      else chk_out($sformatf("wrap%0d", k), 1'b1, 16'(k - 1), 1'b1, 1, 1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("wrap_tail", 1'b1, 16'd19, 1'b1, 1, 1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("wrap_done", 1'b0, 16'h0, 1'b0, 0, 0);

    // Reset mid-message discards the partial message
    drive(1'b1, 1'b0, 16'h0AAA, 1'b1);
    drive(1'b1, 1'b0, 16'h0BBB, 1'b1);
    chk("partial.occ", 32'(bus.occ), 32'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("partial", 1'b0, 16'h0, 1'b0, 0, 2);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    rst = 1'b0;
    chk_out("rst_mid", 1'b0, 16'h0, 1'b0, 0, 0);
    chk("rst_mid.err", 32'(bus.err_overflow), 32'd0);
    drive(1'b1, 1'b1, 16'h0777, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("fresh", 1'b1, 16'h0777, 1'b1, 1, 1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("fresh_done", 1'b0, 16'h0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
